// File: rtl/branch_history_table_pkg.sv
// Shared constants and helpers for the branch history table and its delay line.
package branch_history_table_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned IDX_LSB = 2;

   // Weakly-not-taken start value: one below the counter midpoint.
   function automatic int unsigned ctr_init(input int unsigned ctr_w);
      return (32'd1 << (ctr_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_history_table_delay_line.sv
// Shift register carrying {valid, index, predicted} from decode lookup to MEM-stage update.
module branch_history_table_delay_line
   import branch_history_table_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             pred_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             pred_o
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] pred_q, pred_d;
   logic [IDX_W-1:0] idx_q [DEPTH];
   logic [IDX_W-1:0] idx_d [DEPTH];

   // No stalls in the pipeline, so every slot advances every cycle.
   always_comb begin
      valid_d[0] = valid_i;
      pred_d[0]  = pred_i;
      idx_d[0]   = idx_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
         valid_d[i] = valid_q[i-1];
         pred_d[i]  = pred_q[i-1];
         idx_d[i]   = idx_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         pred_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         pred_q  <= pred_d;
         for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= idx_d[i];
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign pred_o  = pred_q[DEPTH-1];
   assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/branch_history_table.sv
// PC-indexed table of saturating counters: predicts in decode, trains from MEM, counts mispredicts.
module branch_history_table
   import branch_history_table_pkg::*;
#(
   parameter int unsigned INDEX_W        = 6,
   parameter int unsigned CTR_W          = 2,
   parameter int unsigned UPDATE_LATENCY = 2,
   parameter int unsigned PERF_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [PC_W-1:0]   lookup_pc,
   input  logic [PC_W-1:0]   lookup_offset,
   output logic              prediction,
   output logic [PC_W-1:0]   branch_addr,
   input  logic              update_valid,
   input  logic              actual_taken,
   output logic              mispredict,
   output logic [PERF_W-1:0] branch_count,
   output logic [PERF_W-1:0] mispredict_count
);

   localparam int unsigned      ENTRIES  = 1 << INDEX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   logic [CTR_W-1:0]   table_q [ENTRIES];
   logic [INDEX_W-1:0] lookup_idx;
   logic               old_valid, old_pred;
   logic [INDEX_W-1:0] old_idx;
   logic               do_update;
   logic [CTR_W-1:0]   ctr_old, ctr_d;
   logic [PERF_W-1:0]  branch_count_q, branch_count_d;
   logic [PERF_W-1:0]  mispredict_count_q, mispredict_count_d;
   logic               mispredict_q, mispredict_d;

   assign lookup_idx  = lookup_pc[IDX_LSB +: INDEX_W];
   assign prediction  = lookup_valid & table_q[lookup_idx][CTR_W-1];
   assign branch_addr = lookup_pc + lookup_offset;

   branch_history_table_delay_line #(
      .DEPTH (UPDATE_LATENCY),
      .IDX_W (INDEX_W)
   ) u_delay_line (
      .clk     (clk),
      .reset   (reset),
      .valid_i (lookup_valid),
      .idx_i   (lookup_idx),
      .pred_i  (prediction),
      .valid_o (old_valid),
      .idx_o   (old_idx),
      .pred_o  (old_pred)
   );

   // update_valid only acts when the oldest slot holds a live lookup; a flushed branch is a no-op.
   assign do_update = update_valid & old_valid;
   assign ctr_old   = table_q[old_idx];

   always_comb begin
      ctr_d = ctr_old;
      if (actual_taken) begin
         if (ctr_old != CTR_MAX) ctr_d = ctr_old + CTR_W'(1);
      end else begin
         if (ctr_old != '0) ctr_d = ctr_old - CTR_W'(1);
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      mispredict_d       = 1'b0;
      if (do_update) begin
         if (~&branch_count_q) branch_count_d = branch_count_q + PERF_W'(1);
         if (actual_taken != old_pred) begin
            mispredict_d = 1'b1;
            if (~&mispredict_count_q) mispredict_count_d = mispredict_count_q + PERF_W'(1);
         end
      end
   end

   // Lookups read table_q directly, so a same-cycle update is seen only on the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= CTR_INIT;
      end else if (do_update) begin
         table_q[old_idx] <= ctr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
         mispredict_q       <= 1'b0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
         mispredict_q       <= mispredict_d;
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;
   assign mispredict       = mispredict_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed vector table, then random traffic against a queue-based model.
module tb_branch_history_table;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lookup_valid = 1'b0, update_valid = 1'b0, actual_taken = 1'b0;
   logic [31:0] lookup_pc = '0, lookup_offset = '0;
   logic        prediction, mispredict, prediction_s, mispredict_s;
   logic [31:0] branch_addr, branch_addr_s, branch_count, mispredict_count;
   logic [2:0]  branch_count_s, mispredict_count_s;

   branch_history_table #(.INDEX_W(6), .CTR_W(2), .UPDATE_LATENCY(L), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .prediction(prediction), .branch_addr(branch_addr),
      .update_valid(update_valid), .actual_taken(actual_taken), .mispredict(mispredict),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   // Narrow perf counters so saturation is reachable.
   branch_history_table #(.INDEX_W(6), .CTR_W(2), .UPDATE_LATENCY(L), .PERF_W(3)) dut_sat (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_offset(lookup_offset), .prediction(prediction_s), .branch_addr(branch_addr_s),
      .update_valid(update_valid), .actual_taken(actual_taken), .mispredict(mispredict_s),
      .branch_count(branch_count_s), .mispredict_count(mispredict_count_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst, lv;
      logic [31:0] pc, off;
      bit          uv, at, e_pred;
      logic [31:0] e_addr;
      bit          e_mis;
      int          e_bc, e_mc;
   } vec_t;

   typedef struct { bit v; int idx; bit p; } slot_t;

   int    m_ctr [64];
   slot_t m_pipe [$];
   int    m_bc, m_mc;
   bit    m_mis;
   int    n_pass = 0, n_total = 0;
   vec_t  tab [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void model_reset();
      slot_t empty;
      empty = '{v: 1'b0, idx: 0, p: 1'b0};
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_pipe.delete();
      for (int i = 0; i < L; i++) m_pipe.push_back(empty);
      m_bc = 0; m_mc = 0; m_mis = 1'b0;
   endfunction

   function automatic void add(input bit rst, lv, input logic [31:0] pc, off, input bit uv, at,
                               input bit e_pred, input logic [31:0] e_addr, input bit e_mis,
                               input int e_bc, e_mc);
      vec_t v;
      v.rst = rst; v.lv = lv; v.pc = pc; v.off = off; v.uv = uv; v.at = at;
      v.e_pred = e_pred; v.e_addr = e_addr; v.e_mis = e_mis; v.e_bc = e_bc; v.e_mc = e_mc;
      tab.push_back(v);
   endfunction

   function automatic int sat7(input int x);
      return (x > 7) ? 7 : x;
   endfunction

   task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
      int          idx;
      bit          exp_pred;
      logic [31:0] exp_addr;
      slot_t       old, fresh;
      reset = v.rst; lookup_valid = v.lv; lookup_pc = v.pc; lookup_offset = v.off;
      update_valid = v.uv; actual_taken = v.at;
      @(negedge clk);
      idx      = int'(v.pc >> 2) % 64;
      exp_pred = v.lv && (m_ctr[idx] >= 2);
      exp_addr = v.pc + v.off;
      chk({tag, " prediction"},   {31'd0, prediction},   {31'd0, exp_pred});
      chk({tag, " branch_addr"},  branch_addr,           exp_addr);
      chk({tag, " mispredict"},   {31'd0, mispredict},   {31'd0, m_mis});
      chk({tag, " branch_count"}, branch_count,          32'(m_bc));
      chk({tag, " mis_count"},    mispredict_count,      32'(m_mc));
      chk({tag, " sat_bc"},       {29'd0, branch_count_s},     32'(sat7(m_bc)));
      chk({tag, " sat_mc"},       {29'd0, mispredict_count_s}, 32'(sat7(m_mc)));
      if (use_tab) begin
         chk({tag, " tab_pred"}, {31'd0, prediction}, {31'd0, v.e_pred});
         chk({tag, " tab_addr"}, branch_addr,         v.e_addr);
         chk({tag, " tab_mis"},  {31'd0, mispredict}, {31'd0, v.e_mis});
         chk({tag, " tab_bc"},   branch_count,        32'(v.e_bc));
         chk({tag, " tab_mc"},   mispredict_count,    32'(v.e_mc));
      end
      if (v.rst) begin
         model_reset();
      end else begin
         old   = m_pipe.pop_front();
         fresh = '{v: v.lv, idx: idx, p: exp_pred};
         m_pipe.push_back(fresh);
         m_mis = 1'b0;
         if (v.uv && old.v) begin
            if (v.at) begin
               if (m_ctr[old.idx] < 3) m_ctr[old.idx]++;
            end else begin
               if (m_ctr[old.idx] > 0) m_ctr[old.idx]--;
            end
            m_bc++;
            if (v.at != old.p) begin
               m_mc++;
               m_mis = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t rv;
      // reset, lookup, offset, update | expected pred, addr, mispredict, branch_count, mis_count
      add(0,1,32'h40,8,0,0, 0,32'h48,0,0,0);
      add(0,0,0,0,0,0,      0,0,0,0,0);
      add(0,0,0,0,1,1,      0,0,0,0,0);
      add(0,1,32'h40,8,0,0, 1,32'h48,1,1,1);
      add(0,0,0,0,0,0,      0,0,0,1,1);
      add(0,0,0,0,1,1,      0,0,0,1,1);
      add(0,1,32'h40,8,0,0, 1,32'h48,0,2,1);
      add(0,0,0,0,0,0,      0,0,0,2,1);
      add(0,0,0,0,1,1,      0,0,0,2,1);
      add(0,1,32'h40,8,0,0, 1,32'h48,0,3,1);
      add(0,0,0,0,0,0,      0,0,0,3,1);
      add(0,0,0,0,1,1,      0,0,0,3,1);
      add(0,1,32'h40,8,0,0, 1,32'h48,0,4,1);
      add(0,0,0,0,0,0,      0,0,0,4,1);
      add(0,0,0,0,1,0,      0,0,0,4,1);
      add(0,1,32'h40,8,0,0, 1,32'h48,1,5,2);
      add(0,0,0,0,0,0,      0,0,0,5,2);
      add(0,1,32'h140,0,1,0, 1,32'h140,0,5,2);
      add(0,1,32'h140,0,0,0, 0,32'h140,1,6,3);
      add(0,0,0,0,1,1,      0,0,0,6,3);
      add(0,0,0,0,1,0,      0,0,0,7,3);
      add(0,0,0,0,0,0,      0,0,0,8,3);
      add(0,0,32'h40,8,0,0, 0,32'h48,0,8,3);
      add(0,0,0,0,0,0,      0,0,0,8,3);
      add(0,0,0,0,1,1,      0,0,0,8,3);
      add(0,1,32'h40,8,0,0, 0,32'h48,0,8,3);
      add(0,1,32'h40,8,0,0, 0,32'h48,0,8,3);
      add(1,0,0,0,0,0,      0,0,0,8,3);
      add(0,0,0,0,1,1,      0,0,0,0,0);
      add(0,0,0,0,1,1,      0,0,0,0,0);
      add(0,1,32'h40,8,0,0, 0,32'h48,0,0,0);
      add(0,0,32'h100,32'hFFFF_FFF0,0,0, 0,32'h0F0,0,0,0);
      add(0,0,32'hFFFF_FFFC,8,0,0,       0,32'h4,0,0,0);

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      foreach (tab[i]) run_cycle(tab[i], 1'b1, $sformatf("row%0d", i));

      for (int n = 0; n < 500; n++) begin
         rv = '{default: 0};
         rv.rst = ($urandom_range(0, 63) == 0);
         rv.lv  = $urandom_range(0, 1);
         rv.pc  = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
         rv.off = $urandom;
         rv.uv  = $urandom_range(0, 1);
         rv.at  = $urandom_range(0, 1);
         run_cycle(rv, 1'b0, $sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
